traffic_controller: RTL and testbench

Sequencing controller for a main-street/side-street intersection with a pedestrian walk phase. It consumes the already-synchronized sensor, walk-request and reprogram strobes plus a one-cycle timebase tick. It drives the main and side lamp triplets and the walk lamp through a fixed phase cycle with programmable interval lengths. It sits directly downstream of the input synchronizer and directly drives the lamp outputs.

---
 rtl/traffic_controller.sv | 136 +++++++++++++
 tb/tb_traffic_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_controller.sv
// traffic_controller: main/side intersection phase sequencer with tick-driven interval timer.
// Optional pedestrian walk phase is built only when TRAFFIC_WALK_EN is defined.
module traffic_controller #(
   parameter int T_BASE = 6,
   parameter int T_EXT  = 3,
   parameter int T_YEL  = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       sensor_sync,
   input  logic       wr_sync,
   input  logic       prog_sync,
   output logic [2:0] main_lights,
   output logic [2:0] side_lights,
   output logic       walk_lamp,
   output logic [2:0] state_o
);

   localparam logic [2:0] MAIN_GRN = 3'd0;
   localparam logic [2:0] MAIN_EXT = 3'd1;
   localparam logic [2:0] MAIN_YEL = 3'd2;
   localparam logic [2:0] WALK     = 3'd3;
   localparam logic [2:0] SIDE_GRN = 3'd4;
   localparam logic [2:0] SIDE_EXT = 3'd5;
   localparam logic [2:0] SIDE_YEL = 3'd6;

   localparam logic [7:0] LD_BASE = 8'(T_BASE - 1);
   localparam logic [7:0] LD_EXT  = 8'(T_EXT - 1);
   localparam logic [7:0] LD_YEL  = 8'(T_YEL - 1);

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   logic [2:0] state, nxt_state;
   logic [7:0] timer, nxt_timer;
   logic       expire;
   logic       state_ok;

`ifdef TRAFFIC_WALK_EN
   logic walk_pending;
`else
   logic unused_wr;
   assign unused_wr = wr_sync;
`endif

   function automatic logic [7:0] load_val(input logic [2:0] s);
      case (s)
         MAIN_GRN, SIDE_GRN: load_val = LD_BASE;
         MAIN_YEL, SIDE_YEL: load_val = LD_YEL;
         default:            load_val = LD_EXT;
      endcase
   endfunction

   assign expire = tick && (timer == 8'd0);

`ifdef TRAFFIC_WALK_EN
   assign state_ok = (state != 3'd7);
`else
   assign state_ok = (state != 3'd7) && (state != WALK);
`endif

   always_comb begin
      nxt_state = state;
      nxt_timer = timer;
      if (!state_ok) begin
         nxt_state = MAIN_GRN;
      end else if (expire) begin
         case (state)
            MAIN_GRN: nxt_state = sensor_sync ? MAIN_EXT : MAIN_YEL;
            MAIN_EXT: nxt_state = MAIN_YEL;
`ifdef TRAFFIC_WALK_EN
            MAIN_YEL: nxt_state = walk_pending ? WALK : SIDE_GRN;
            WALK:     nxt_state = SIDE_GRN;
`else
            MAIN_YEL: nxt_state = SIDE_GRN;
`endif
            SIDE_GRN: nxt_state = sensor_sync ? SIDE_EXT : SIDE_YEL;
            SIDE_EXT: nxt_state = SIDE_YEL;
            default:  nxt_state = MAIN_GRN;
         endcase
      end
      // Every expiry leaves the state, so a state change is exactly an entry.
      if (nxt_state != state)
         nxt_timer = load_val(nxt_state);
      else if (tick)
         nxt_timer = timer - 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset || prog_sync) begin
         state <= MAIN_GRN;
         timer <= LD_BASE;
      end else begin
         state <= nxt_state;
         timer <= nxt_timer;
      end
   end

`ifdef TRAFFIC_WALK_EN
   // Clearing on the entry transition beats a request arriving in the same cycle.
   always_ff @(posedge clock) begin
      if (reset || prog_sync)
         walk_pending <= 1'b0;
      else if (nxt_state == WALK && state != WALK)
         walk_pending <= 1'b0;
      else if (wr_sync)
         walk_pending <= 1'b1;
   end
`endif

   always_comb begin
      main_lights = RED;
      side_lights = RED;
      case (state)
         MAIN_GRN, MAIN_EXT: main_lights = GRN;
         MAIN_YEL:           main_lights = YEL;
         SIDE_GRN, SIDE_EXT: side_lights = GRN;
         SIDE_YEL:           side_lights = YEL;
         default: begin
            main_lights = RED;
            side_lights = RED;
         end
      endcase
   end

`ifdef TRAFFIC_WALK_EN
   assign walk_lamp = (state == WALK);
`else
   assign walk_lamp = 1'b0;
`endif

   assign state_o = state;

endmodule

// File: tb/tb_traffic_controller.sv
// tb_traffic_controller: directed scenarios plus random stimulus, checked every cycle
// against a phase/elapsed-tick model of the intersection sequence.
module tb_traffic_controller;

`ifdef TRAFFIC_WALK_EN
   localparam bit WALK_EN = 1'b1;
`else
   localparam bit WALK_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       sensor_sync = 1'b0;
   logic       wr_sync = 1'b0;
   logic       prog_sync = 1'b0;
   logic [2:0] main_lights;
   logic [2:0] side_lights;
   logic       walk_lamp;
   logic [2:0] state_o;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   traffic_controller #(.T_BASE(6), .T_EXT(3), .T_YEL(2)) dut (
      .clock(clock), .reset(reset), .tick(tick), .sensor_sync(sensor_sync),
      .wr_sync(wr_sync), .prog_sync(prog_sync), .main_lights(main_lights),
      .side_lights(side_lights), .walk_lamp(walk_lamp), .state_o(state_o)
   );

   always #5 clock = ~clock;

   // Model: current phase, ticks elapsed in it, and the pending walk request.
   int m_ph = 0;
   int m_el = 0;
   bit m_pend = 1'b0;

   function automatic int dur(input int ph);
      case (ph)
         0, 4:    return 6;
         2, 6:    return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [2:0] exp_main(input int ph);
      case (ph)
         0, 1:    return 3'b001;
         2:       return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_side(input int ph);
      case (ph)
         4, 5:    return 3'b001;
         6:       return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   always @(posedge clock) begin
      int ph, el;
      bit pend, into_walk;
      ph = m_ph; el = m_el; pend = m_pend; into_walk = 1'b0;
      if (reset || prog_sync) begin
         ph = 0; el = 0; pend = 1'b0;
      end else begin
         if (tick) begin
            el = el + 1;
            if (el == dur(m_ph)) begin
               el = 0;
               case (m_ph)
                  0: ph = sensor_sync ? 1 : 2;
                  1: ph = 2;
                  2: begin
                     ph = (WALK_EN && m_pend) ? 3 : 4;
                     into_walk = (ph == 3);
                  end
                  3: ph = 4;
                  4: ph = sensor_sync ? 5 : 6;
                  5: ph = 6;
                  default: ph = 0;
               endcase
            end
         end
         if (into_walk) pend = 1'b0;
         else if (wr_sync && WALK_EN) pend = 1'b1;
      end
      m_ph <= ph;
      m_el <= el;
      m_pend <= pend;
   end

   always @(negedge clock) begin
      if (chk_en) begin
         n_cmp = n_cmp + 5;
         if (state_o != 3'(m_ph)) begin
            n_bad++; $display("FAIL model_state t=%0t got %0d want %0d", $time, state_o, m_ph);
         end
         if (main_lights != exp_main(m_ph)) begin
            n_bad++; $display("FAIL model_main t=%0t got %b want %b", $time, main_lights, exp_main(m_ph));
         end
         if (side_lights != exp_side(m_ph)) begin
            n_bad++; $display("FAIL model_side t=%0t got %b want %b", $time, side_lights, exp_side(m_ph));
         end
         if (walk_lamp != (m_ph == 3)) begin
            n_bad++; $display("FAIL model_walk t=%0t got %0d want %0d", $time, walk_lamp, (m_ph == 3));
         end
         if (main_lights != 3'b100 && side_lights != 3'b100) begin
            n_bad++; $display("FAIL safety t=%0t got main %b side %b want one red", $time, main_lights, side_lights);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
      end
   endtask

   task automatic clk1();
      @(negedge clock);
   endtask

   task automatic tk(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1; clk1();
         tick = 1'b0; clk1(); clk1(); clk1();
      end
   endtask

   task automatic pulse_wr();
      wr_sync = 1'b1; clk1(); wr_sync = 1'b0;
   endtask

   task automatic tick_with_prog();
      tick = 1'b1; prog_sync = 1'b1; clk1();
      tick = 1'b0; prog_sync = 1'b0; clk1(); clk1(); clk1();
   endtask

   initial begin
      clk1();
      chk_en = 1'b1;
      clk1(); clk1();
      chk("rst_state", state_o, 0);
      chk("rst_main", main_lights, 3'b001);
      chk("rst_side", side_lights, 3'b100);
      chk("rst_walk", walk_lamp, 0);
      reset = 1'b0;

      // Idle cycle: 0,2,4,6,0 dwelling 6,2,6,2.
      tk(5); chk("idle_g_hold", state_o, 0);
      tk(1); chk("idle_my", state_o, 2); chk("idle_my_main", main_lights, 3'b010);
      tk(2); chk("idle_sg", state_o, 4); chk("idle_sg_side", side_lights, 3'b001);
      tk(6); chk("idle_sy", state_o, 6);
      tk(2); chk("idle_back", state_o, 0);

      // Sensor extension: 0,1,2,4,5,6 dwelling 6,3,2,6,3,2.
      sensor_sync = 1'b1;
      tk(6); chk("ext_me", state_o, 1);
      tk(3); chk("ext_my", state_o, 2);
      tk(2); chk("ext_sg", state_o, 4);
      tk(6); chk("ext_se", state_o, 5);
      tk(3); chk("ext_sy", state_o, 6);
      tk(2); chk("ext_back", state_o, 0);
      sensor_sync = 1'b0;

      // Walk request pulse during MAIN_GRN.
      pulse_wr();
      tk(6); chk("walk_my", state_o, 2);
      tk(2); chk("walk_entry", state_o, WALK_EN ? 3 : 4);
      chk("walk_lamp_on", walk_lamp, WALK_EN ? 1 : 0);
      chk("walk_main_red", main_lights, WALK_EN ? 3'b100 : 3'b100);
      tk(WALK_EN ? 3 : 0); chk("walk_to_sg", state_o, 4);
      tk(8); chk("walk_cyc_main", state_o, 0);
      tk(8); chk("walk_skip", state_o, 4);

      // Request on the WALK entry cycle is absorbed by the clear.
      tk(8); chk("race_main", state_o, 0);
      pulse_wr();
      tk(6); tk(1);
      tick = 1'b1; wr_sync = 1'b1; clk1();
      tick = 1'b0; wr_sync = 1'b0; clk1(); clk1(); clk1();
      chk("race_entry", state_o, WALK_EN ? 3 : 4);
      tk(WALK_EN ? 3 : 0);
      tk(16); chk("race_skip", state_o, 4);

      // Reprogram at tick 3 of SIDE_GRN, then coinciding with a yellow expiry.
      tk(2); tick_with_prog();
      chk("prog_state", state_o, 0); chk("prog_main", main_lights, 3'b001);
      tk(5); chk("prog_hold", state_o, 0);
      tk(1); chk("prog_my", state_o, 2);
      tk(1); tick_with_prog();
      chk("prog_exp_state", state_o, 0);
      tk(5); chk("prog_exp_hold", state_o, 0);
      tk(1); chk("prog_exp_my", state_o, 2);

      // Reset in WALK.
      pulse_wr();
      tk(2); chk("rw_entry", state_o, WALK_EN ? 3 : 4);
      tk(1);
      reset = 1'b1; clk1(); reset = 1'b0;
      chk("rw_state", state_o, 0); chk("rw_main", main_lights, 3'b001);
      chk("rw_side", side_lights, 3'b100); chk("rw_walk", walk_lamp, 0);
      tk(8); chk("rw_skip", state_o, 4);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         tick = ($urandom_range(0, 2) == 0);
         sensor_sync = $urandom_range(0, 1);
         wr_sync = ($urandom_range(0, 15) == 0);
         prog_sync = ($urandom_range(0, 249) == 0);
         reset = ($urandom_range(0, 499) == 0);
         clk1();
      end
      tick = 1'b0; sensor_sync = 1'b0; wr_sync = 1'b0; prog_sync = 1'b0; reset = 1'b0;
      clk1(); clk1();
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
